// File: rtl/axi_sram_slave_if.sv
// AXI3 channel bundle between a cache-side master and the SRAM responder.
interface axi_sram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 INCR-burst responder over a word-addressed RAM, independent read and write FSMs.
// Define AXI_SRAM_RANGE_CHK_EN to answer SLVERR for addresses above the RAM instead of aliasing.
module axi_sram_slave #(
    parameter int    ADDR_W   = 12,
    parameter string INIT_HEX = ""
) (
    input  logic            clk,
    input  logic            rst,
    axi_sram_slave_if.slave s
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic       {R_IDLE, R_BURST}        rstate_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

    logic [31:0] mem [0:DEPTH-1];

    logic ar_oor, aw_oor;
`ifdef AXI_SRAM_RANGE_CHK_EN
    assign ar_oor = |s.araddr[31:ADDR_W+2];
    assign aw_oor = |s.awaddr[31:ADDR_W+2];
`else
    assign ar_oor = 1'b0;
    assign aw_oor = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{s.arsize, s.arburst, s.awsize, s.awburst, s.wid,
                           s.araddr[1:0], s.awaddr[1:0],
                           s.araddr[31:ADDR_W+2], s.awaddr[31:ADDR_W+2]};

    // Handshakes stay low until the first clock after reset release.
    logic alive_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) alive_q <= 1'b0;
        else     alive_q <= 1'b1;
    end

    rstate_e           rstate_q, rstate_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [3:0]        rcnt_q, rcnt_d, rid_q, rid_d;
    logic              roor_q, roor_d;
    logic [31:0]       rdata_q;
    logic              rd_fetch, arready, rvalid;

    always_comb begin
        rstate_d = rstate_q;
        raddr_d  = raddr_q;
        rcnt_d   = rcnt_q;
        rid_d    = rid_q;
        roor_d   = roor_q;
        rd_fetch = 1'b0;
        arready  = 1'b0;
        rvalid   = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                arready = alive_q;
                if (alive_q && s.arvalid) begin
                    raddr_d  = s.araddr[ADDR_W+1:2];
                    rcnt_d   = s.arlen;
                    rid_d    = s.arid;
                    roor_d   = ar_oor;
                    rd_fetch = 1'b1;
                    rstate_d = R_BURST;
                end
            end
            R_BURST: begin
                rvalid = 1'b1;
                if (s.rready) begin
                    if (rcnt_q == 4'd0) begin
                        rstate_d = R_IDLE;
                    end else begin
                        raddr_d  = raddr_q + ADDR_W'(1);
                        rcnt_d   = rcnt_q - 4'd1;
                        rd_fetch = 1'b1;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate_q <= R_IDLE;
            raddr_q  <= '0;
            rcnt_q   <= '0;
            rid_q    <= '0;
            roor_q   <= 1'b0;
        end else begin
            rstate_q <= rstate_d;
            raddr_q  <= raddr_d;
            rcnt_q   <= rcnt_d;
            rid_q    <= rid_d;
            roor_q   <= roor_d;
        end
    end

    // Registered read port: a write landing on this same edge is not yet visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           rdata_q <= '0;
        else if (rd_fetch) rdata_q <= roor_d ? 32'h0 : mem[raddr_d];
    end

    assign s.arready = arready;
    assign s.rvalid  = rvalid;
    assign s.rdata   = rdata_q;
    assign s.rid     = rid_q;
    assign s.rlast   = rvalid && (rcnt_q == 4'd0);
    assign s.rresp   = (rvalid && roor_q) ? 2'b10 : 2'b00;

    wstate_e           wstate_q, wstate_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [3:0]        wcnt_q, wcnt_d, bid_q, bid_d;
    logic              werr_q, werr_d, woor_q, woor_d;
    logic              wr_beat, awready, wready, bvalid;

    always_comb begin
        wstate_d = wstate_q;
        waddr_d  = waddr_q;
        wcnt_d   = wcnt_q;
        bid_d    = bid_q;
        werr_d   = werr_q;
        woor_d   = woor_q;
        wr_beat  = 1'b0;
        awready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                awready = alive_q;
                if (alive_q && s.awvalid) begin
                    waddr_d  = s.awaddr[ADDR_W+1:2];
                    wcnt_d   = s.awlen;
                    bid_d    = s.awid;
                    woor_d   = aw_oor;
                    werr_d   = 1'b0;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (s.wvalid) begin
                    wr_beat = 1'b1;
                    // The beat count, not wlast, ends the burst; a mismatch is only reported.
                    if (s.wlast != (wcnt_q == 4'd0)) werr_d = 1'b1;
                    waddr_d = waddr_q + ADDR_W'(1);
                    wcnt_d  = wcnt_q - 4'd1;
                    if (wcnt_q == 4'd0) wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (s.bready) begin
                    werr_d   = 1'b0;
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q <= W_IDLE;
            waddr_q  <= '0;
            wcnt_q   <= '0;
            bid_q    <= '0;
            werr_q   <= 1'b0;
            woor_q   <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            waddr_q  <= waddr_d;
            wcnt_q   <= wcnt_d;
            bid_q    <= bid_d;
            werr_q   <= werr_d;
            woor_q   <= woor_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_beat && !woor_q) begin
            for (int i = 0; i < 4; i++) begin
                if (s.wstrb[i]) mem[waddr_q][8*i +: 8] <= s.wdata[8*i +: 8];
            end
        end
    end

    assign s.awready = awready;
    assign s.wready  = wready;
    assign s.bvalid  = bvalid;
    assign s.bid     = bid_q;
    assign s.bresp   = bvalid ? {werr_q | woor_q, 1'b0} : 2'b00;
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: bursts, strobes, backpressure, wlast errors, concurrency, reset.
module tb_axi_sram_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_sram_slave_if bus ();

    axi_sram_slave #(.ADDR_W(12), .INIT_HEX("")) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] rd_data [16];
    logic        rd_last [16];
    logic [3:0]  rd_id   [16];
    logic [1:0]  rd_resp [16];
    int          rd_cyc  [16];
    int          rd_beats;
    int          rd_hold_bad;
    bit          rd_to;

    logic [31:0] wdat [16];
    logic [1:0]  wr_bresp;
    logic [3:0]  wr_bid;
    logic        wr_b_now;
    bit          wr_to;

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input bit toggle, input int stop_at);
        int cyc;
        int t;
        logic [31:0] held;
        bit hold;
        rd_beats = 0; rd_to = 0; rd_hold_bad = 0; hold = 0; t = 0; held = '0;
        @(negedge clk);
        bus.arid = id; bus.araddr = addr; bus.arlen = len;
        bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arvalid = 1'b1;
        while (bus.arready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) rd_to = 1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        cyc = 0;
        while (!rd_to && rd_beats <= int'(len) && rd_beats != stop_at) begin
            bus.rready = toggle ? (cyc % 3 == 0) : 1'b1;
            if (hold && bus.rdata !== held) rd_hold_bad++;
            if (bus.rvalid === 1'b1 && bus.rready) begin
                rd_data[rd_beats] = bus.rdata;
                rd_last[rd_beats] = bus.rlast;
                rd_id[rd_beats]   = bus.rid;
                rd_resp[rd_beats] = bus.rresp;
                rd_cyc[rd_beats]  = cyc;
                rd_beats++;
                hold = 0;
            end else if (bus.rvalid === 1'b1) begin
                held = bus.rdata;
                hold = 1;
            end
            @(negedge clk);
            cyc++;
            if (cyc > 100) rd_to = 1;
        end
        bus.rready = 1'b0;
    endtask

    // bad_last < 0: wlast on the final beat; otherwise wlast only on beat index bad_last.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [3:0] strb, input int bad_last);
        int t;
        int b;
        wr_to = 0; t = 0; b = 0;
        @(negedge clk);
        bus.awid = id; bus.awaddr = addr; bus.awlen = len;
        bus.awsize = 3'd2; bus.awburst = 2'b01; bus.awvalid = 1'b1;
        while (bus.awready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) wr_to = 1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        t = 0;
        while (!wr_to && b <= int'(len)) begin
            bus.wvalid = 1'b1; bus.wid = id; bus.wdata = wdat[b]; bus.wstrb = strb;
            bus.wlast  = (bad_last < 0) ? (b == int'(len)) : (b == bad_last);
            if (bus.wready === 1'b1) b++;
            @(negedge clk);
            t++;
            if (t > 100) wr_to = 1;
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        wr_b_now = bus.bvalid;
        bus.bready = 1'b1; t = 0;
        while (bus.bvalid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) wr_to = 1;
        wr_bresp = bus.bresp; wr_bid = bus.bid;
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] obs;
        logic [31:0] exp;
        repeat (2) @(negedge clk);
        obs = {bus.arready, bus.awready, bus.rvalid, bus.wready, bus.bvalid, bus.rlast,
               bus.rid, bus.bid, bus.rresp, bus.bresp, 12'h0};
        exp = 32'h0;
        n_cmp++;
        if (obs !== exp) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", obs, exp); end
        n_cmp++;
        if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.arready, bus.awready} !== 2'b11) begin
            n_fail++; $display("FAIL reset_ready: got %b want 11", {bus.arready, bus.awready});
        end
    endtask

    task automatic test_write_burst;
        for (int i = 0; i < 16; i++) wdat[i] = 32'hC0DE0000 + i;
        do_write(4'd1, 32'h40, 4'd15, 4'hF, -1);
        n_cmp++;
        if ({wr_to, wr_bresp, wr_bid} !== {1'b0, 2'b00, 4'd1}) begin
            n_fail++; $display("FAIL wburst_b: got to=%0d resp=%0d id=%0d want 0/0/1", wr_to, wr_bresp, wr_bid);
        end
    endtask

    task automatic test_read_burst;
        do_read(4'd3, 32'h40, 4'd15, 1'b0, -1);
        n_cmp++;
        if (rd_to || rd_beats != 16) begin n_fail++; $display("FAIL rburst_beats: got %0d want 16", rd_beats); end
        for (int i = 0; i < rd_beats; i++) begin
            n_cmp++;
            if ({rd_data[i], rd_last[i], rd_id[i], rd_resp[i]} !== {32'hC0DE0000 + i, i == 15, 4'd3, 2'b00}
                || rd_cyc[i] != i) begin
                n_fail++;
                $display("FAIL rburst_beat%0d: got d=%h l=%b id=%0d r=%0d cyc=%0d want d=%h l=%b id=3 r=0 cyc=%0d",
                         i, rd_data[i], rd_last[i], rd_id[i], rd_resp[i], rd_cyc[i], 32'hC0DE0000 + i, i == 15, i);
            end
        end
        n_cmp++;
        if ({bus.arready, bus.rvalid} !== 2'b10) begin
            n_fail++; $display("FAIL rburst_after: got arready,rvalid=%b want 10", {bus.arready, bus.rvalid});
        end
    endtask

    task automatic test_strobe;
        wdat[0] = 32'h11223344;
        do_write(4'd0, 32'h8, 4'd0, 4'hF, -1);
        wdat[0] = 32'hAABBCCDD;
        do_write(4'd4, 32'h8, 4'd0, 4'b0101, -1);
        n_cmp++;
        if ({wr_b_now, wr_bresp, wr_bid} !== {1'b1, 2'b00, 4'd4}) begin
            n_fail++; $display("FAIL strobe_b: got bnow=%b resp=%0d id=%0d want 1/0/4", wr_b_now, wr_bresp, wr_bid);
        end
        do_read(4'd0, 32'h8, 4'd0, 1'b0, -1);
        n_cmp++;
        if (rd_beats != 1 || {rd_data[0], rd_last[0]} !== {32'h11BB33DD, 1'b1}) begin
            n_fail++; $display("FAIL strobe_data: got %h last=%b want 11bb33dd last=1", rd_data[0], rd_last[0]);
        end
    endtask

    task automatic test_backpressure;
        do_read(4'd6, 32'h40, 4'd15, 1'b1, -1);
        n_cmp++;
        if (rd_to || rd_beats != 16 || rd_hold_bad != 0) begin
            n_fail++; $display("FAIL bp_beats: got beats=%0d holdbad=%0d want 16/0", rd_beats, rd_hold_bad);
        end
        for (int i = 0; i < rd_beats; i++) begin
            n_cmp++;
            if (rd_data[i] !== 32'hC0DE0000 + i || rd_last[i] !== (i == 15) || rd_cyc[i] != 3 * i) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got d=%h l=%b cyc=%0d want d=%h l=%b cyc=%0d",
                         i, rd_data[i], rd_last[i], rd_cyc[i], 32'hC0DE0000 + i, i == 15, 3 * i);
            end
        end
    endtask

    task automatic test_wlast_err;
        for (int i = 0; i < 4; i++) wdat[i] = 32'hD0 + i;
        do_write(4'd2, 32'h200, 4'd3, 4'hF, 1);
        n_cmp++;
        if ({wr_to, wr_bresp, wr_bid} !== {1'b0, 2'b10, 4'd2}) begin
            n_fail++; $display("FAIL wlast_b: got to=%0d resp=%0d id=%0d want 0/2/2", wr_to, wr_bresp, wr_bid);
        end
        do_read(4'd1, 32'h200, 4'd3, 1'b0, -1);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_data[i] !== 32'hD0 + i) begin
                n_fail++; $display("FAIL wlast_data%0d: got %h want %h", i, rd_data[i], 32'hD0 + i);
            end
        end
        wdat[0] = 32'h55;
        do_write(4'd3, 32'h300, 4'd0, 4'hF, -1);
        n_cmp++;
        if (wr_bresp !== 2'b00) begin n_fail++; $display("FAIL wlast_clear: got resp=%0d want 0", wr_bresp); end
    endtask

    task automatic test_wrap;
        wdat[0] = 32'h0F0F0001; wdat[1] = 32'h0F0F0002;
        do_write(4'd1, 32'h3FFC, 4'd1, 4'hF, -1);
        do_read(4'd1, 32'h0, 4'd0, 1'b0, -1);
        n_cmp++;
        if (rd_data[0] !== 32'h0F0F0002) begin n_fail++; $display("FAIL wrap_w: got %h want 0f0f0002", rd_data[0]); end
        do_read(4'd1, 32'h3FFC, 4'd1, 1'b0, -1);
        n_cmp++;
        if ({rd_data[0], rd_data[1]} !== {32'h0F0F0001, 32'h0F0F0002}) begin
            n_fail++; $display("FAIL wrap_r: got %h %h want 0f0f0001 0f0f0002", rd_data[0], rd_data[1]);
        end
    endtask

    task automatic test_concurrent;
        for (int i = 0; i < 16; i++) wdat[i] = 32'h1000 + i;
        do_write(4'd0, 32'h100, 4'd15, 4'hF, -1);
        for (int i = 0; i < 16; i++) wdat[i] = 32'hA5A5A5A5;
        fork
            do_read(4'd5, 32'h100, 4'd15, 1'b0, -1);
            do_write(4'd9, 32'h100, 4'd15, 4'hF, -1);
        join
        n_cmp++;
        if (rd_to || wr_to || rd_beats != 16 || {wr_bid, wr_bresp} !== {4'd9, 2'b00}) begin
            n_fail++; $display("FAIL conc_done: got beats=%0d bid=%0d bresp=%0d", rd_beats, wr_bid, wr_bresp);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if ({rd_data[i], rd_id[i]} !== {32'h1000 + i, 4'd5}) begin
                n_fail++; $display("FAIL conc_beat%0d: got d=%h id=%0d want d=%h id=5", i, rd_data[i], rd_id[i], 32'h1000 + i);
            end
        end
        do_read(4'd5, 32'h100, 4'd15, 1'b0, -1);
        n_cmp++;
        if (rd_data[0] !== 32'hA5A5A5A5 || rd_data[15] !== 32'hA5A5A5A5) begin
            n_fail++; $display("FAIL conc_new: got %h %h want a5a5a5a5", rd_data[0], rd_data[15]);
        end
    endtask

    task automatic test_reset_mid;
        do_read(4'd7, 32'h40, 4'd15, 1'b0, 5);
        n_cmp++;
        if (rd_beats != 5 || rd_data[4] !== 32'hC0DE0004) begin
            n_fail++; $display("FAIL rstmid_pre: got beats=%0d d4=%h want 5 c0de0004", rd_beats, rd_data[4]);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.rvalid, bus.rlast, bus.arready} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_idle: got rvalid,rlast,arready=%b want 000", {bus.rvalid, bus.rlast, bus.arready});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.arready, bus.awready, bus.rvalid} !== 3'b110) begin
            n_fail++; $display("FAIL rstmid_rel: got %b want 110", {bus.arready, bus.awready, bus.rvalid});
        end
        do_read(4'd2, 32'h44, 4'd3, 1'b0, -1);
        n_cmp++;
        if (rd_beats != 4 || {rd_data[0], rd_data[3], rd_last[3], rd_id[3]} !== {32'hC0DE0001, 32'hC0DE0004, 1'b1, 4'd2}) begin
            n_fail++; $display("FAIL rstmid_new: got beats=%0d d0=%h d3=%h", rd_beats, rd_data[0], rd_data[3]);
        end
    endtask

    task automatic test_range;
`ifdef AXI_SRAM_RANGE_CHK_EN
        do_read(4'd1, 32'hFFFF0000, 4'd1, 1'b0, -1);
        n_cmp++;
        if ({rd_data[0], rd_resp[0], rd_data[1], rd_resp[1]} !== {32'h0, 2'b10, 32'h0, 2'b10}) begin
            n_fail++; $display("FAIL range_rd: got %h/%0d %h/%0d want 0/2", rd_data[0], rd_resp[0], rd_data[1], rd_resp[1]);
        end
        wdat[0] = 32'hDEADBEEF;
        do_write(4'd1, 32'hFFFF0040, 4'd0, 4'hF, -1);
        n_cmp++;
        if (wr_bresp !== 2'b10) begin n_fail++; $display("FAIL range_wr: got resp=%0d want 2", wr_bresp); end
        do_read(4'd1, 32'h40, 4'd0, 1'b0, -1);
        n_cmp++;
        if (rd_data[0] !== 32'hC0DE0000) begin n_fail++; $display("FAIL range_keep: got %h want c0de0000", rd_data[0]); end
`else
        do_read(4'd1, 32'hFFFF0040, 4'd0, 1'b0, -1);
        n_cmp++;
        if ({rd_data[0], rd_resp[0]} !== {32'hC0DE0000, 2'b00}) begin
            n_fail++; $display("FAIL alias_rd: got %h/%0d want c0de0000/0", rd_data[0], rd_resp[0]);
        end
`endif
    endtask

    initial begin
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        test_reset;
        test_write_burst;
        test_read_burst;
        test_strobe;
        test_backpressure;
        test_wlast_err;
        test_wrap;
        test_concurrent;
        test_reset_mid;
        test_range;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
